// File: rtl/display_pkg.sv
// display_pkg: shared widths, FSM state encoding and digit helpers for the display refresh controller
package display_pkg;
  localparam int NUM_DIGITS = 7;
  localparam int CHAR_W = 7;
  localparam int ANODE_W = 8;
  localparam int CHARS_W = NUM_DIGITS * CHAR_W;
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_e;
  // Digit index step with wrap from the leftmost digit back to digit 0
  function automatic logic [2:0] next_digit(input logic [2:0] d);
    return (d == 3'(NUM_DIGITS - 1)) ? 3'd0 : d + 3'd1;
  endfunction
  // Active-low one-hot anode pattern for a digit; the unused top anode stays high
  function automatic logic [ANODE_W-1:0] digit_anode(input logic [2:0] d);
    return ~(ANODE_W'(1) << d);
  endfunction
endpackage

// File: rtl/refresh_prescaler.sv
// refresh_prescaler: per-slot tick counter flagging the end of the blank phase and of the slot
module refresh_prescaler #(
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS = 1000
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               run,
  output logic [$clog2(TICKS_PER_DIGIT)-1:0] count,
  output logic                               slot_end,
  output logic                               blank_end
);
  localparam int CW = $clog2(TICKS_PER_DIGIT);
  localparam logic HAS_BLANK = BLANK_TICKS != 0;
  localparam int BLANK_LAST = HAS_BLANK ? BLANK_TICKS - 1 : 0;
  logic [CW-1:0] count_q, count_d;
  assign slot_end = run && count_q == CW'(TICKS_PER_DIGIT - 1);
  assign blank_end = run && HAS_BLANK && count_q == CW'(BLANK_LAST);
  assign count_d = (!run || slot_end) ? '0 : count_q + 1'b1;
  assign count = count_q;
  // Count within the slot; cleared at every slot boundary and whenever scanning stops
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/display_refresh_controller.sv
// display_refresh_controller: multiplexed 7-digit scan with anti-ghost blanking and frame-aligned character updates
module display_refresh_controller
  import display_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               upd_valid,
  input  logic [CHARS_W-1:0] upd_chars,
  output logic               upd_ready,
  output logic [CHAR_W-1:0]  char1,
  output logic [CHAR_W-1:0]  char2,
  output logic [CHAR_W-1:0]  char3,
  output logic [CHAR_W-1:0]  char4,
  output logic [CHAR_W-1:0]  char5,
  output logic [CHAR_W-1:0]  char6,
  output logic [CHAR_W-1:0]  char7,
  output logic [2:0]         refresh_counter,
  output logic [ANODE_W-1:0] anode_n,
  output logic               frame_start
);
  localparam int CW = $clog2(TICKS_PER_DIGIT);
  localparam logic NO_BLANK = BLANK_TICKS == 0;
  state_e state_q;
  state_e entry_state;
  logic [2:0] digit_q, digit_d;
  logic [ANODE_W-1:0] anode_q;
  logic frame_q;
  logic pending_q;
  logic [CHARS_W-1:0] shadow_q, chars_q;
  logic [CW-1:0] tick_cnt;
  logic run, slot_end, blank_end, accept, commit;
  assign run = enable && state_q != IDLE;
  assign digit_d = next_digit(digit_q);
  assign entry_state = NO_BLANK ? SHOW : BLANK;
  assign accept = upd_valid && !pending_q;
  assign commit = pending_q && (state_q == IDLE || (enable && state_q == SHOW && slot_end && digit_d == 3'd0));
  refresh_prescaler #(
    .TICKS_PER_DIGIT(TICKS_PER_DIGIT),
    .BLANK_TICKS(BLANK_TICKS)
  ) u_prescaler (
    .clk(clk),
    .rst_n(rst_n),
    .run(run),
    .count(tick_cnt),
    .slot_end(slot_end),
    .blank_end(blank_end)
  );
  // Scan FSM: slot sequencing with registered anode, digit index and frame pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      digit_q <= '0;
      anode_q <= '1;
      frame_q <= 1'b0;
    end else if (!enable) begin
      state_q <= IDLE;
      digit_q <= '0;
      anode_q <= '1;
      frame_q <= 1'b0;
    end else begin
      frame_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q <= entry_state;
          digit_q <= '0;
          anode_q <= NO_BLANK ? digit_anode(3'd0) : '1;
          frame_q <= 1'b1;
        end
        BLANK: if (blank_end) begin
          state_q <= SHOW;
          anode_q <= digit_anode(digit_q);
        end
        SHOW: if (slot_end) begin
          state_q <= entry_state;
          digit_q <= digit_d;
          anode_q <= NO_BLANK ? digit_anode(digit_d) : '1;
          frame_q <= digit_d == 3'd0;
        end
        default: state_q <= IDLE;
      endcase
    end
  // Update path: accept into the shadow, then commit only at a frame boundary or while idle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pending_q <= 1'b0;
      shadow_q <= '0;
      chars_q <= '0;
    end else begin
      if (accept) begin
        shadow_q <= upd_chars;
        pending_q <= 1'b1;
      end
      if (commit) begin
        chars_q <= shadow_q;
        pending_q <= 1'b0;
      end
    end
  // The slot counter must sit at zero whenever the scan is idle
  always_ff @(posedge clk)
    if (rst_n && state_q == IDLE) assert (tick_cnt == '0);
  assign upd_ready = !pending_q;
  assign refresh_counter = digit_q;
  assign anode_n = anode_q;
  assign frame_start = frame_q;
  assign char1 = chars_q[6:0];
  assign char2 = chars_q[13:7];
  assign char3 = chars_q[20:14];
  assign char4 = chars_q[27:21];
  assign char5 = chars_q[34:28];
  assign char6 = chars_q[41:35];
  assign char7 = chars_q[48:42];
endmodule

// File: tb/tb_display_refresh_controller.sv
// tb_display_refresh_controller: table-driven scan checks plus a commit scoreboard for character updates
module tb_display_refresh_controller;
  localparam int T = 4;
  localparam logic [48:0] V1 = 49'h1_0204_0810_2040;
  localparam logic [48:0] V2 = 49'h1_ABCD_EF01_2345;
  localparam logic [48:0] V3 = 49'h0_5555_AAAA_3333;
  typedef struct {
    logic [2:0] digit;
    logic [7:0] anode;
  } slot_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic en_nb = 1'b0;
  logic upd_valid = 1'b0;
  logic [48:0] upd_chars = '0;
  logic upd_ready, frame_start;
  logic [6:0] c [1:7];
  logic [2:0] refresh_counter;
  logic [7:0] anode_n;
  logic nb_ready, nb_fs;
  logic [6:0] nb_c [1:7];
  logic [2:0] nb_rc;
  logic [7:0] nb_anode;
  slot_t slots [7];
  logic [48:0] sb [$];
  int checks = 0;
  int failures = 0;
  logic mon_en = 1'b0;
  logic [48:0] prev = '0;
  logic [48:0] cur;
  always #5 clk = ~clk;
  display_refresh_controller #(.TICKS_PER_DIGIT(T), .BLANK_TICKS(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .upd_valid(upd_valid), .upd_chars(upd_chars),
    .upd_ready(upd_ready), .char1(c[1]), .char2(c[2]), .char3(c[3]), .char4(c[4]),
    .char5(c[5]), .char6(c[6]), .char7(c[7]), .refresh_counter(refresh_counter),
    .anode_n(anode_n), .frame_start(frame_start)
  );
  display_refresh_controller #(.TICKS_PER_DIGIT(T), .BLANK_TICKS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .enable(en_nb), .upd_valid(1'b0), .upd_chars(49'h0),
    .upd_ready(nb_ready), .char1(nb_c[1]), .char2(nb_c[2]), .char3(nb_c[3]), .char4(nb_c[4]),
    .char5(nb_c[5]), .char6(nb_c[6]), .char7(nb_c[7]), .refresh_counter(nb_rc),
    .anode_n(nb_anode), .frame_start(nb_fs)
  );
  function automatic logic [48:0] chars_now();
    return {c[7], c[6], c[5], c[4], c[3], c[2], c[1]};
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic offer(input logic [48:0] v, input int bound);
    bit done;
    done = 0;
    upd_valid = 1'b1;
    upd_chars = v;
    for (int i = 0; i < bound && !done; i++) begin
      if (upd_ready) begin
        sb.push_back(v);
        done = 1;
      end
      @(negedge clk);
    end
    upd_valid = 1'b0;
    chk("offer_accepted", 64'(done), 1);
  endtask
  task automatic wait_empty(input int bound);
    int n;
    n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("commit_within_bound", 64'(sb.size() == 0), 1);
  endtask
  always @(negedge clk)
    if (mon_en) begin
      cur = chars_now();
      if (cur !== prev) begin
        chk("commit_expected", 64'(sb.size() != 0), 1);
        if (sb.size() != 0) chk("commit_value", cur, sb.pop_front());
        chk("commit_on_frame_start", frame_start, 1);
        chk("ready_after_commit", upd_ready, 1);
        prev = cur;
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n;
    slots[0] = '{3'd0, 8'hFE};
    slots[1] = '{3'd1, 8'hFD};
    slots[2] = '{3'd2, 8'hFB};
    slots[3] = '{3'd3, 8'hF7};
    slots[4] = '{3'd4, 8'hEF};
    slots[5] = '{3'd5, 8'hDF};
    slots[6] = '{3'd6, 8'hBF};
    #12;
    chk("rst_anode", anode_n, 8'hFF);
    chk("rst_digit", refresh_counter, 0);
    chk("rst_frame", frame_start, 0);
    chk("rst_ready", upd_ready, 1);
    chk("rst_chars", chars_now(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    mon_en = 1'b1;
    for (int f = 0; f < 2; f++)
      for (int s = 0; s < 7; s++)
        for (int t = 0; t < T; t++) begin
          @(negedge clk);
          chk("scan_anode", anode_n, t == 0 ? 8'hFF : slots[s].anode);
          chk("scan_digit", refresh_counter, slots[s].digit);
          chk("scan_frame", frame_start, 64'(s == 0 && t == 0));
        end
    repeat (5) tick();
    offer(V1, 5);
    chk("ready_low_pending", upd_ready, 0);
    chk("chars_held_midframe", chars_now(), 0);
    repeat (3) tick();
    offer(V2, 40);
    chk("v1_committed", chars_now(), V1);
    chk("v1_char1", c[1], 7'h40);
    chk("v1_char7", c[7], 7'h40);
    chk("v2_pending", upd_ready, 0);
    wait_empty(40);
    chk("v2_committed", chars_now(), V2);
    n = 0;
    while (!(refresh_counter == 3'd3 && anode_n == 8'hF7) && n < 40) begin
      tick();
      n++;
    end
    chk("reach_digit3_show", 64'(n < 40), 1);
    enable = 1'b0;
    tick();
    chk("dis_anode", anode_n, 8'hFF);
    chk("dis_digit", refresh_counter, 0);
    chk("dis_frame", frame_start, 0);
    tick();
    chk("dis_idle_anode", anode_n, 8'hFF);
    enable = 1'b1;
    tick();
    chk("reen_anode", anode_n, 8'hFF);
    chk("reen_frame", frame_start, 1);
    chk("reen_digit", refresh_counter, 0);
    tick();
    chk("reen_show", anode_n, 8'hFE);
    chk("reen_frame_low", frame_start, 0);
    repeat (3) tick();
    offer(V3, 5);
    n = 0;
    while (anode_n == 8'hFF && n < 10) begin
      tick();
      n++;
    end
    chk("reach_show", 64'(anode_n != 8'hFF), 1);
    #2;
    rst_n = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("arst_anode", anode_n, 8'hFF);
    chk("arst_digit", refresh_counter, 0);
    chk("arst_frame", frame_start, 0);
    chk("arst_ready", upd_ready, 1);
    chk("arst_chars", chars_now(), 0);
    sb.delete();
    prev = '0;
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (40) tick();
    chk("arst_no_commit", chars_now(), 0);
    chk("arst_ready_after", upd_ready, 1);
    enable = 1'b0;
    en_nb = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("nb_anode", nb_anode, slots[(i / T) % 7].anode);
      chk("nb_digit", nb_rc, slots[(i / T) % 7].digit);
      chk("nb_frame", nb_fs, 64'(i == 0 || i == 28));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
